// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared definitions for the register write-back path.
//   WB_DATA_W : default result width
//   REG_PC    : register index that maps to the program counter
//   NUM_GPR   : number of scoreboarded general-purpose registers (R0..R14)
//   wb_entry_t: one buffered result {rd, data}
package reg_writeback_ctrl_pkg;
  localparam int         WB_DATA_W = 32;
  localparam logic [3:0] REG_PC    = 4'd15;
  localparam int         NUM_GPR   = 15;

  typedef struct packed {
    logic [3:0]           rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Bundle of all non-clock signals of the write-back controller.
//   slave  : controller side (takes results/issue/read indices, drives write port)
//   master : producer side (execute, MCycle, decode, register file observer)
interface reg_writeback_ctrl_if #(parameter int DATA_W = 32);
  // ALU result (never back-pressured)
  logic              ALU_Valid;
  logic [3:0]        ALU_Rd;
  logic [DATA_W-1:0] ALU_Data;
  // multi-cycle result handshake
  logic              MC_Valid;
  logic              MC_Ready;
  logic [3:0]        MC_Rd;
  logic [DATA_W-1:0] MC_Data;
  // scoreboard issue / hazard query
  logic              Issue_Valid;
  logic [3:0]        Issue_Rd;
  logic [3:0]        RA1;
  logic [3:0]        RA2;
  logic              Hazard1;
  logic              Hazard2;
  logic [14:0]       Busy_Vec;
  // register-file write port and PC write
  logic              WE3;
  logic [3:0]        A3;
  logic [DATA_W-1:0] WD3;
  logic              PCWrite;
  logic [DATA_W-1:0] PCData;

  modport slave (
    input  ALU_Valid, ALU_Rd, ALU_Data, MC_Valid, MC_Rd, MC_Data,
           Issue_Valid, Issue_Rd, RA1, RA2,
    output MC_Ready, Hazard1, Hazard2, Busy_Vec, WE3, A3, WD3, PCWrite, PCData
  );

  modport master (
    output ALU_Valid, ALU_Rd, ALU_Data, MC_Valid, MC_Rd, MC_Data,
           Issue_Valid, Issue_Rd, RA1, RA2,
    input  MC_Ready, Hazard1, Hazard2, Busy_Vec, WE3, A3, WD3, PCWrite, PCData
  );
endinterface

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// wb_fifo: small synchronous FIFO for buffered multi-cycle results.
//   CLK/RESETn : clock, async active-low reset (empties the FIFO)
//   push/pop   : requests; ignored when full/empty respectively
//   full/empty : status from registered count
//   head       : entry at the read pointer (valid when !empty)
module wb_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RESETn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // storage needs no reset: contents are only observed through cnt
  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= din;
  end

  // power-of-2 depth: pointers wrap by natural overflow
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: merges ALU and multi-cycle results into one registered
// register-file write per cycle, R15 results become a PC write pulse.
//   CLK, RESETn : clock, async active-low reset
//   bus (slave) : ALU result, MC result handshake, issue/scoreboard, hazard
//                 query, WE3/A3/WD3 write port, PCWrite/PCData
// ALU has priority; MC results are buffered in wb_fifo and drained when the
// ALU is idle. The scoreboard tracks MC destinations in flight.
module reg_writeback_ctrl
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESETn,
  reg_writeback_ctrl_if.slave bus
);
  localparam int EW = 4 + DATA_W;

  logic              full, empty, push, pop;
  logic [EW-1:0]     head;
  logic              win_alu, win_mc, win;
  logic [3:0]        win_rd;
  logic [DATA_W-1:0] win_data;
  logic [NUM_GPR-1:0] busy_q, set_vec, clr_vec;
  logic [15:0]       set_oh, clr_oh, busy_ext;

  assign push         = bus.MC_Valid && !full;
  assign bus.MC_Ready = !full;

  wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .RESETn(RESETn),
    .push  (push),
    .din   ({bus.MC_Rd, bus.MC_Data}),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // one winner per cycle: ALU, else FIFO head
  always_comb begin
    win_alu  = bus.ALU_Valid;
    win_mc   = !bus.ALU_Valid && !empty;
    win      = win_alu || win_mc;
    win_rd   = head[EW-1 -: 4];
    win_data = head[DATA_W-1:0];
    if (win_alu) begin
      win_rd   = bus.ALU_Rd;
      win_data = bus.ALU_Data;
    end
  end

  assign pop = win_mc;

  // one-hot decode; bit 15 (PC) falls off the 15-bit scoreboard
  assign set_oh  = 16'(1) << bus.Issue_Rd;
  assign clr_oh  = 16'(1) << win_rd;
  assign set_vec = bus.Issue_Valid ? set_oh[NUM_GPR-1:0] : '0;
  assign clr_vec = win_mc ? clr_oh[NUM_GPR-1:0] : '0;

  // clear first, then set, so a same-cycle issue keeps the register busy
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) busy_q <= '0;
    else         busy_q <= (busy_q & ~clr_vec) | set_vec;
  end

  assign busy_ext     = {1'b0, busy_q};
  assign bus.Busy_Vec = busy_q;
  assign bus.Hazard1  = busy_ext[bus.RA1];
  assign bus.Hazard2  = busy_ext[bus.RA2];

  // output register; address/data hold when nothing commits
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      bus.WE3     <= 1'b0;
      bus.A3      <= '0;
      bus.WD3     <= '0;
      bus.PCWrite <= 1'b0;
      bus.PCData  <= '0;
    end else begin
      bus.WE3     <= win && (win_rd != REG_PC);
      bus.PCWrite <= win && (win_rd == REG_PC);
      if (win && (win_rd != REG_PC)) begin
        bus.A3  <= win_rd;
        bus.WD3 <= win_data;
      end
      if (win && (win_rd == REG_PC)) bus.PCData <= win_data;
    end
  end
endmodule
